// File: rtl/rr_or_arbiter_pkg.sv
// Shared definitions for the round-robin OR-datapath arbiter:
// FSM state encoding, requester limit and a constant-friendly clog2.
package rr_or_arbiter_pkg;

  localparam int N_MAX = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Ceiling log2; clog2(1) = 0, clog2(9) = 4.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational circular priority encoder: finds the first set request
// scanning from i_ptr upward and wrapping modulo N.
module rr_priority_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic           o_any,
  output logic [N-1:0]   o_pick,
  output logic [IDW-1:0] o_index
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IDW:0]   w_sum;
  logic           w_found;

  // Rotate requests so bit k holds requester (ptr+k) mod N, then take the lowest set bit.
  always_comb begin
    o_any   = |i_req;
    o_index = '0;
    o_pick  = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_dbl   = {i_req, i_req} >> i_ptr;
    w_rot   = w_dbl[N-1:0];
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(N)) begin
        w_sum = w_sum - (IDW+1)'(N);
      end else begin
        w_sum = w_sum;
      end
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        o_index = w_sum[IDW-1:0];
      end else begin
        w_found = w_found;
      end
    end
    for (int j = 0; j < N; j++) begin
      o_pick[j] = w_found && (o_index == IDW'(j));
    end
  end

endmodule

// File: rtl/rr_or_arbiter.sv
// Round-robin arbiter granting one requester at a time access to the shared
// OR datapath; a grant ends on done, request drop or the hold limit.
module rr_or_arbiter
  import rr_or_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8,
  parameter int IDW      = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           timeout
);

  // HOLD_MAX = 0 still gets a 1-bit counter; it saturates instead of wrapping.
  localparam int              HCW_RAW   = clog2(HOLD_MAX + 1);
  localparam int              HCW       = (HCW_RAW < 1) ? 1 : HCW_RAW;
  localparam logic [HCW-1:0]  HOLD_LAST = (HOLD_MAX == 0) ? '0 : HCW'(HOLD_MAX - 1);
  localparam logic [IDW-1:0]  ID_LAST   = IDW'(N - 1);

  state_e         r_state, w_state_nxt;
  logic [IDW-1:0] r_ptr, w_ptr_nxt;
  logic [HCW-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [N-1:0]   r_grant, w_grant_nxt;
  logic [IDW-1:0] r_grant_id, w_grant_id_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_timeout, w_timeout_nxt;

  logic           w_any;
  logic [N-1:0]   w_pick;
  logic [IDW-1:0] w_pick_id;
  logic           w_owner_req;
  logic           w_limit;
  logic           w_release;

  rr_priority_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_any   (w_any),
    .o_pick  (w_pick),
    .o_index (w_pick_id)
  );

  assign w_owner_req = |(req & r_grant);
  assign w_limit     = (HOLD_MAX != 0) && (r_hold_cnt == HOLD_LAST);
  assign w_release   = (r_state == GRANT) && (done || !w_owner_req || w_limit);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = GRANT;
        else       w_state_nxt = IDLE;
      end
      GRANT: begin
        if (w_release) w_state_nxt = IDLE;
        else           w_state_nxt = GRANT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values for grant outputs, pointer and hold counter.
  always_comb begin
    w_grant_nxt    = '0;
    w_grant_id_nxt = '0;
    w_busy_nxt     = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_ptr_nxt      = r_ptr;
    w_hold_cnt_nxt = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt    = w_pick;
          w_grant_id_nxt = w_pick_id;
          w_busy_nxt     = 1'b1;
        end else begin
          w_grant_nxt    = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_ptr_nxt     = (r_grant_id == ID_LAST) ? '0 : r_grant_id + 1'b1;
          // Normal completion (done or request drop) masks the limit pulse.
          w_timeout_nxt = w_limit && !done && w_owner_req;
        end else begin
          w_grant_nxt    = r_grant;
          w_grant_id_nxt = r_grant_id;
          w_busy_nxt     = 1'b1;
          w_hold_cnt_nxt = (r_hold_cnt == '1) ? r_hold_cnt : r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_ptr_nxt = '0;
      end
    endcase
  end

  // Output, pointer and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant    <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_busy     <= w_busy_nxt;
      r_timeout  <= w_timeout_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_rr_or_arbiter.sv
// Directed scoreboard bench: a 4-requester and a 3-requester arbiter, each
// step queues its expected outputs and compares them after the clock edge.
module tb_rr_or_arbiter;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] id;
    logic       busy;
    logic       timeout;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic       done  = 1'b0;
  logic [2:0] req3  = 3'b000;
  logic       done3 = 1'b0;

  logic [3:0] grant4;
  logic [1:0] id4;
  logic       busy4;
  logic       to4;
  logic [2:0] grant3;
  logic [1:0] id3;
  logic       busy3;
  logic       to3;

  exp_t q4[$];
  exp_t q3[$];
  int   checks   = 0;
  int   failures = 0;

  rr_or_arbiter #(.N(4), .HOLD_MAX(8), .IDW(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant(grant4), .grant_id(id4), .busy(busy4), .timeout(to4)
  );

  rr_or_arbiter #(.N(3), .HOLD_MAX(8), .IDW(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .done(done3),
    .grant(grant3), .grant_id(id3), .busy(busy3), .timeout(to3)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] g, input logic t);
    exp_t e;
    e.grant   = g;
    e.busy    = |g;
    e.timeout = t;
    e.id      = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) e.id = 2'(i);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc4(input logic [3:0] r, input logic d, input logic [3:0] g,
                      input logic t, input string tag);
    exp_t e;
    @(negedge clk);
    req  = r;
    done = d;
    q4.push_back(mk(g, t));
    @(posedge clk);
    #1;
    e = q4.pop_front();
    chk({tag, ".grant"},   grant4,         e.grant);
    chk({tag, ".id"},      {2'b00, id4},   {2'b00, e.id});
    chk({tag, ".busy"},    {3'b000, busy4}, {3'b000, e.busy});
    chk({tag, ".timeout"}, {3'b000, to4},   {3'b000, e.timeout});
  endtask

  task automatic cyc3(input logic [2:0] r, input logic d, input logic [3:0] g,
                      input logic t, input string tag);
    exp_t e;
    @(negedge clk);
    req3  = r;
    done3 = d;
    q3.push_back(mk(g, t));
    @(posedge clk);
    #1;
    e = q3.pop_front();
    chk({tag, ".grant"},   {1'b0, grant3}, e.grant);
    chk({tag, ".id"},      {2'b00, id3},   {2'b00, e.id});
    chk({tag, ".busy"},    {3'b000, busy3}, {3'b000, e.busy});
    chk({tag, ".timeout"}, {3'b000, to3},   {3'b000, e.timeout});
  endtask

  initial begin
    logic [3:0] g;

    rst_n = 1'b0;
    cyc4(4'b0000, 1'b0, 4'b0000, 1'b0, "reset4");
    cyc3(3'b000, 1'b0, 4'b0000, 1'b0, "reset3");
    rst_n = 1'b1;

    // Single requester, done on the third cycle after the grant.
    cyc4(4'b0001, 1'b0, 4'b0001, 1'b0, "single_grant");
    cyc4(4'b0001, 1'b0, 4'b0001, 1'b0, "single_hold1");
    cyc4(4'b0001, 1'b0, 4'b0001, 1'b0, "single_hold2");
    cyc4(4'b0001, 1'b1, 4'b0000, 1'b0, "single_done");
    cyc4(4'b0000, 1'b0, 4'b0000, 1'b0, "single_idle");

    rst_n = 1'b0;
    cyc4(4'b0000, 1'b0, 4'b0000, 1'b0, "reset_again");
    rst_n = 1'b1;

    // Fairness with all requesters active.
    for (int k = 0; k < 5; k++) begin
      g = 4'(1 << (k % 4));
      cyc4(4'b1111, 1'b0, g,       1'b0, "fair_grant");
      cyc4(4'b1111, 1'b0, g,       1'b0, "fair_hold");
      cyc4(4'b1111, 1'b1, 4'b0000, 1'b0, "fair_bubble");
    end

    // Hold limit: exactly 8 granted cycles, then a timeout pulse, then re-grant.
    for (int i = 0; i < 8; i++) begin
      cyc4(4'b0100, 1'b0, 4'b0100, 1'b0, "hold_cycle");
    end
    cyc4(4'b0100, 1'b0, 4'b0000, 1'b1, "hold_timeout");
    cyc4(4'b0100, 1'b0, 4'b0100, 1'b0, "hold_regrant");
    cyc4(4'b0000, 1'b0, 4'b0000, 1'b0, "hold_drop");

    // Request drop mid-grant moves the pointer past the dropped owner.
    cyc4(4'b0010, 1'b0, 4'b0010, 1'b0, "drop_grant");
    cyc4(4'b0010, 1'b0, 4'b0010, 1'b0, "drop_hold");
    cyc4(4'b0000, 1'b0, 4'b0000, 1'b0, "drop_release");
    cyc4(4'b1111, 1'b0, 4'b0100, 1'b0, "drop_ptr2");
    cyc4(4'b1111, 1'b1, 4'b0000, 1'b0, "drop_done");

    // done coincides with the hold limit: release without timeout.
    for (int i = 0; i < 8; i++) begin
      cyc4(4'b1000, 1'b0, 4'b1000, 1'b0, "coll_hold");
    end
    cyc4(4'b1000, 1'b1, 4'b0000, 1'b0, "coll_release");
    cyc4(4'b0000, 1'b1, 4'b0000, 1'b0, "idle_done_ignored");

    // Reset in the middle of a grant.
    cyc4(4'b1000, 1'b0, 4'b1000, 1'b0, "mid_grant");
    cyc4(4'b1000, 1'b0, 4'b1000, 1'b0, "mid_hold");
    rst_n = 1'b0;
    cyc4(4'b1000, 1'b0, 4'b0000, 1'b0, "mid_reset");
    rst_n = 1'b1;
    cyc4(4'b1001, 1'b0, 4'b0001, 1'b0, "post_reset_ptr0");
    cyc4(4'b0000, 1'b0, 4'b0000, 1'b0, "post_reset_release");

    // Non-power-of-two requester count.
    for (int k = 0; k < 4; k++) begin
      g = 4'(1 << (k % 3));
      cyc3(3'b111, 1'b0, g,       1'b0, "n3_grant");
      cyc3(3'b111, 1'b1, 4'b0000, 1'b0, "n3_done");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
